// File: rtl/mux_pkg.sv
// mux_pkg -- constants and helpers shared by the N-way select datapath.
//   MUX_DATA_WIDTH    : default word width of the datapath muxes
//   MUX_DEFAULT_VALUE : word driven for an out-of-range select
//   sel_width()       : select width for N inputs, never below 1
package mux_pkg;

  localparam int          MUX_DATA_WIDTH    = 32;
  localparam logic [31:0] MUX_DEFAULT_VALUE = 32'h0000_0000;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_comb.sv
// mux_n_comb -- pure combinational N-way select with out-of-range detection.
//   data_i : flattened inputs, input k at [k*DATA_WIDTH +: DATA_WIDTH]
//   sel_i  : binary select
//   word_o : selected word, DEFAULT_VALUE when sel_i >= NUM_INPUTS
//   err_o  : out-of-range flag (only when MUX_SEL_ERR_EN is defined)
module mux_n_comb #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    NUM_INPUTS    = 4,
  parameter int                    SEL_WIDTH     = 2,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = '0
) (
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] data_i,
  input  logic [SEL_WIDTH-1:0]             sel_i,
  output logic [DATA_WIDTH-1:0]            word_o
`ifdef MUX_SEL_ERR_EN
  ,
  output logic                             err_o
`endif
);

  logic                  hit;
  logic [DATA_WIDTH-1:0] sel_word;

  // Equality scan rather than a range compare: codes past NUM_INPUTS-1
  // simply never hit, which covers non-power-of-two input counts.
  always_comb begin
    hit      = 1'b0;
    sel_word = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (sel_i == SEL_WIDTH'(k)) begin
        hit      = 1'b1;
        sel_word = data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign word_o = hit ? sel_word : DEFAULT_VALUE;
`ifdef MUX_SEL_ERR_EN
  assign err_o  = !hit;
`endif

endmodule

// File: rtl/mux_n_skid.sv
// mux_n_skid -- N-way select with registered output and one-beat skid buffer.
//   clk, rst_n          : clock (rising), async active-low reset
//   in_Data/in_Sel      : flattened inputs and binary select
//   in_Valid/in_Ready   : upstream handshake; in_Ready is a pure register
//   flush               : synchronous flush, drops held and concurrent beats
//   out_Data/out_Sel    : registered word and the select that produced it
//   out_Valid/out_Ready : downstream handshake
//   sel_Err             : out-of-range flag travelling with the beat
// Optional: define MUX_SEL_ERR_EN to add sel_Err and its storage.
module mux_n_skid import mux_pkg::*; #(
  parameter int                    DATA_WIDTH    = MUX_DATA_WIDTH,
  parameter int                    NUM_INPUTS    = 4,
  parameter int                    SEL_WIDTH     = sel_width(NUM_INPUTS),
  parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = DATA_WIDTH'(MUX_DEFAULT_VALUE)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_Data,
  input  logic [SEL_WIDTH-1:0]             in_Sel,
  input  logic                             in_Valid,
  output logic                             in_Ready,
  input  logic                             flush,
  output logic [DATA_WIDTH-1:0]            out_Data,
  output logic [SEL_WIDTH-1:0]             out_Sel,
  output logic                             out_Valid,
  input  logic                             out_Ready
`ifdef MUX_SEL_ERR_EN
  ,
  output logic                             sel_Err
`endif
);

  logic [DATA_WIDTH-1:0] word;
  logic                  accept, m_free;

  logic                  m_vld_q, m_vld_d, s_vld_q, s_vld_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
  logic [SEL_WIDTH-1:0]  m_sel_q, m_sel_d, s_sel_q, s_sel_d;
`ifdef MUX_SEL_ERR_EN
  logic                  err;
  logic                  m_err_q, m_err_d, s_err_q, s_err_d;
`endif

  mux_n_comb #(
    .DATA_WIDTH   (DATA_WIDTH),
    .NUM_INPUTS   (NUM_INPUTS),
    .SEL_WIDTH    (SEL_WIDTH),
    .DEFAULT_VALUE(DEFAULT_VALUE)
  ) u_sel (
    .data_i(in_Data),
    .sel_i (in_Sel),
    .word_o(word)
`ifdef MUX_SEL_ERR_EN
    ,
    .err_o (err)
`endif
  );

  assign in_Ready = !s_vld_q;
  assign accept   = in_Valid && !s_vld_q;
  assign m_free   = !m_vld_q || out_Ready;

  always_comb begin
    m_vld_d  = m_vld_q;
    m_data_d = m_data_q;
    m_sel_d  = m_sel_q;
    s_vld_d  = s_vld_q;
    s_data_d = s_data_q;
    s_sel_d  = s_sel_q;
`ifdef MUX_SEL_ERR_EN
    m_err_d  = m_err_q;
    s_err_d  = s_err_q;
`endif
    if (flush) begin
      // Payload registers keep their contents; only validity is dropped.
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (s_vld_q) begin
      // S only fills behind a full M, and in_Ready is low, so no accept here.
      if (out_Ready) begin
        m_data_d = s_data_q;
        m_sel_d  = s_sel_q;
`ifdef MUX_SEL_ERR_EN
        m_err_d  = s_err_q;
`endif
        s_vld_d  = 1'b0;
      end
    end else if (m_free) begin
      m_vld_d = accept;
      if (accept) begin
        m_data_d = word;
        m_sel_d  = in_Sel;
`ifdef MUX_SEL_ERR_EN
        m_err_d  = err;
`endif
      end
    end else if (accept) begin
      s_vld_d  = 1'b1;
      s_data_d = word;
      s_sel_d  = in_Sel;
`ifdef MUX_SEL_ERR_EN
      s_err_d  = err;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld_q  <= 1'b0;
      m_data_q <= '0;
      m_sel_q  <= '0;
      s_vld_q  <= 1'b0;
      s_data_q <= '0;
      s_sel_q  <= '0;
`ifdef MUX_SEL_ERR_EN
      m_err_q  <= 1'b0;
      s_err_q  <= 1'b0;
`endif
    end else begin
      m_vld_q  <= m_vld_d;
      m_data_q <= m_data_d;
      m_sel_q  <= m_sel_d;
      s_vld_q  <= s_vld_d;
      s_data_q <= s_data_d;
      s_sel_q  <= s_sel_d;
`ifdef MUX_SEL_ERR_EN
      m_err_q  <= m_err_d;
      s_err_q  <= s_err_d;
`endif
    end
  end

  assign out_Valid = m_vld_q;
  assign out_Data  = m_data_q;
  assign out_Sel   = m_sel_q;
`ifdef MUX_SEL_ERR_EN
  // Gated by valid so a flushed error beat does not keep the flag raised.
  assign sel_Err   = m_vld_q && m_err_q;
`endif

endmodule

// File: tb/tb_mux_n_skid.sv
// tb_mux_n_skid -- bench for mux_n_skid: a 4-input instance checked against a
// capacity-2 FIFO reference model, plus a 3-input instance for the
// out-of-range select case. Build with MUX_SEL_ERR_EN to cover sel_Err.
module tb_mux_n_skid;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  s;
    logic        e;
  } beat_t;

  logic        clk, rst_n;
  logic [31:0] din [4];
  logic [127:0] in_Data;
  logic [1:0]  in_Sel, out_Sel;
  logic        in_Valid, in_Ready, flush, out_Valid, out_Ready, sel_Err;
  logic [31:0] out_Data;

  logic [31:0] din3 [3];
  logic [95:0] in_Data3;
  logic [1:0]  in_Sel3, out_Sel3;
  logic        in_Valid3, in_Ready3, flush3, out_Valid3, out_Ready3, sel_Err3;
  logic [31:0] out_Data3;

  int    checks = 0, errors = 0, n_xfer = 0;
  beat_t q[$];

  assign in_Data  = {din[3], din[2], din[1], din[0]};
  assign in_Data3 = {din3[2], din3[1], din3[0]};

  mux_n_skid #(.DATA_WIDTH(32), .NUM_INPUTS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_Data(in_Data), .in_Sel(in_Sel),
    .in_Valid(in_Valid), .in_Ready(in_Ready), .flush(flush),
    .out_Data(out_Data), .out_Sel(out_Sel), .out_Valid(out_Valid),
    .out_Ready(out_Ready)
`ifdef MUX_SEL_ERR_EN
    , .sel_Err(sel_Err)
`endif
  );

  mux_n_skid #(.DATA_WIDTH(32), .NUM_INPUTS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_Data(in_Data3), .in_Sel(in_Sel3),
    .in_Valid(in_Valid3), .in_Ready(in_Ready3), .flush(flush3),
    .out_Data(out_Data3), .out_Sel(out_Sel3), .out_Valid(out_Valid3),
    .out_Ready(out_Ready3)
`ifdef MUX_SEL_ERR_EN
    , .sel_Err(sel_Err3)
`endif
  );

`ifndef MUX_SEL_ERR_EN
  assign sel_Err  = 1'b0;
  assign sel_Err3 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the block is a FIFO of depth two that drops everything on flush.
  function automatic beat_t model_beat(input logic [1:0] sel);
    beat_t b;
    b.s = sel;
    b.e = (int'(sel) >= 4);
    b.d = b.e ? 32'h0 : din[sel];
    return b;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      automatic int sz = q.size();
      checks++;
      if (in_Ready !== (sz < 2)) begin
        errors++;
        $display("FAIL mon_in_ready t=%0t got %b want %b", $time, in_Ready, sz < 2);
      end
      checks++;
      if (out_Valid !== (sz != 0)) begin
        errors++;
        $display("FAIL mon_out_valid t=%0t got %b want %b", $time, out_Valid, sz != 0);
      end
      if (sz != 0) begin
        checks++;
        if (out_Data !== q[0].d || out_Sel !== q[0].s) begin
          errors++;
          $display("FAIL mon_out_beat t=%0t got %h/%0d want %h/%0d",
                   $time, out_Data, out_Sel, q[0].d, q[0].s);
        end
`ifdef MUX_SEL_ERR_EN
        checks++;
        if (sel_Err !== q[0].e) begin
          errors++;
          $display("FAIL mon_sel_err t=%0t got %b want %b", $time, sel_Err, q[0].e);
        end
`endif
        if (out_Ready) begin
          void'(q.pop_front());
          n_xfer++;
        end
      end
      if (flush) q.delete();
      else if (in_Valid && sz < 2) q.push_back(model_beat(in_Sel));
    end
  end

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (out_Valid !== 1'b0 || out_Data !== 32'h0 || out_Sel !== 2'd0 || in_Ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_vals got v=%b d=%h s=%0d r=%b want 0/0/0/1",
               out_Valid, out_Data, out_Sel, in_Ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_Ready !== 1'b1 || out_Valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got r=%b v=%b want 1/0", in_Ready, out_Valid);
    end
  endtask

  task automatic test_basic();
    din[0] = 32'h11; din[1] = 32'h22; din[2] = 32'h33; din[3] = 32'h44;
    out_Ready = 1'b1;
    @(negedge clk); in_Valid = 1'b1; in_Sel = 2'd2;
    @(negedge clk); in_Valid = 1'b0;
    checks++;
    if (out_Valid !== 1'b1 || out_Data !== 32'h33 || out_Sel !== 2'd2) begin
      errors++;
      $display("FAIL basic_select got v=%b d=%h s=%0d want 1/33/2", out_Valid, out_Data, out_Sel);
    end
    @(negedge clk);
    checks++;
    if (out_Valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain got v=%b want 0", out_Valid);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk); out_Ready = 1'b0; in_Valid = 1'b1; in_Sel = 2'd0;
    @(negedge clk);
    checks++;
    if (out_Data !== 32'h11 || in_Ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_first got d=%h r=%b want 11/1", out_Data, in_Ready);
    end
    in_Sel = 2'd1;
    @(negedge clk);
    checks++;
    if (out_Data !== 32'h11 || in_Ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_skid_full got d=%h r=%b want 11/0", out_Data, in_Ready);
    end
    in_Sel = 2'd2;
    @(negedge clk);
    checks++;
    if (out_Data !== 32'h11 || in_Ready !== 1'b0 || out_Valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold got d=%h r=%b v=%b want 11/0/1", out_Data, in_Ready, out_Valid);
    end
    out_Ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_Data !== 32'h22 || in_Ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_second got d=%h r=%b want 22/1", out_Data, in_Ready);
    end
    @(negedge clk);
    in_Valid = 1'b0;
    checks++;
    if (out_Data !== 32'h33 || out_Valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_third got d=%h v=%b want 33/1", out_Data, out_Valid);
    end
    @(negedge clk);
    checks++;
    if (out_Valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty got v=%b want 0", out_Valid);
    end
  endtask

  task automatic test_flush();
    @(negedge clk); out_Ready = 1'b0; in_Valid = 1'b1; in_Sel = 2'd3;
    @(negedge clk); in_Sel = 2'd0;
    @(negedge clk);
    checks++;
    if (in_Ready !== 1'b0 || out_Data !== 32'h44) begin
      errors++;
      $display("FAIL flush_setup got r=%b d=%h want 0/44", in_Ready, out_Data);
    end
    flush = 1'b1; in_Sel = 2'd1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (out_Valid !== 1'b0 || in_Ready !== 1'b1 || out_Data !== 32'h44) begin
      errors++;
      $display("FAIL flush_full got v=%b r=%b d=%h want 0/1/44", out_Valid, in_Ready, out_Data);
    end
    in_Sel = 2'd2;
    @(negedge clk);
    checks++;
    if (out_Valid !== 1'b1 || out_Data !== 32'h33) begin
      errors++;
      $display("FAIL flush_refill got v=%b d=%h want 1/33", out_Valid, out_Data);
    end
    flush = 1'b1; in_Sel = 2'd1;
    @(negedge clk);
    flush = 1'b0; in_Valid = 1'b0;
    checks++;
    if (out_Valid !== 1'b0 || in_Ready !== 1'b1 || out_Data !== 32'h33) begin
      errors++;
      $display("FAIL flush_concurrent got v=%b r=%b d=%h want 0/1/33", out_Valid, in_Ready, out_Data);
    end
    out_Ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_Valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_ghost got v=%b want 0", out_Valid);
    end
  endtask

  task automatic test_throughput();
    int n0 = n_xfer;
    out_Ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (in_Ready !== 1'b1 || (i > 0 && out_Valid !== 1'b1)) begin
        errors++;
        $display("FAIL tput_cycle%0d got r=%b v=%b want 1/1", i, in_Ready, out_Valid);
      end
      din[i % 4] = $urandom;
      in_Valid = 1'b1; in_Sel = 2'(i % 4);
    end
    @(negedge clk); in_Valid = 1'b0;
    @(negedge clk);
    checks++;
    if (n_xfer - n0 !== 20) begin
      errors++;
      $display("FAIL tput_count got %0d want 20", n_xfer - n0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) din[k] = $urandom;
      in_Valid  = $urandom_range(0, 3) != 0;
      out_Ready = $urandom_range(0, 2) != 0;
      in_Sel    = 2'($urandom_range(0, 3));
      flush     = $urandom_range(0, 19) == 0;
    end
    @(negedge clk); in_Valid = 1'b0; flush = 1'b0; out_Ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_Valid !== 1'b0 || q.size() != 0) begin
      errors++;
      $display("FAIL rand_drain got v=%b left=%0d want 0/0", out_Valid, q.size());
    end
  endtask

  task automatic test_reset_midstream();
    din[0] = 32'hA5A5_0001; din[1] = 32'hA5A5_0002;
    @(negedge clk); out_Ready = 1'b0; in_Valid = 1'b1; in_Sel = 2'd0;
    @(negedge clk); in_Sel = 2'd1;
    @(negedge clk); in_Valid = 1'b0;
    checks++;
    if (in_Ready !== 1'b0 || out_Valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_setup got r=%b v=%b want 0/1", in_Ready, out_Valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_Valid !== 1'b0 || out_Data !== 32'h0 || in_Ready !== 1'b1 || out_Sel !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_async got v=%b d=%h r=%b s=%0d want 0/0/1/0",
               out_Valid, out_Data, in_Ready, out_Sel);
    end
    @(negedge clk); rst_n = 1'b1; out_Ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_Valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_lost got v=%b want 0", out_Valid);
    end
  endtask

  task automatic test_out_of_range();
    din3[0] = 32'hA1; din3[1] = 32'hB2; din3[2] = 32'hC3;
    out_Ready3 = 1'b1;
    @(negedge clk); in_Valid3 = 1'b1; in_Sel3 = 2'd1;
    @(negedge clk);
    checks++;
    if (out_Valid3 !== 1'b1 || out_Data3 !== 32'hB2 || sel_Err3 !== 1'b0) begin
      errors++;
      $display("FAIL oor_inrange got v=%b d=%h e=%b want 1/b2/0", out_Valid3, out_Data3, sel_Err3);
    end
    in_Sel3 = 2'd3;
    @(negedge clk); in_Valid3 = 1'b0;
    checks++;
    if (out_Valid3 !== 1'b1 || out_Data3 !== 32'h0 || out_Sel3 !== 2'd3) begin
      errors++;
      $display("FAIL oor_default got v=%b d=%h s=%0d want 1/0/3", out_Valid3, out_Data3, out_Sel3);
    end
`ifdef MUX_SEL_ERR_EN
    checks++;
    if (sel_Err3 !== 1'b1) begin
      errors++;
      $display("FAIL oor_sel_err got %b want 1", sel_Err3);
    end
`endif
    @(negedge clk);
    checks++;
    if (out_Valid3 !== 1'b0 || sel_Err3 !== 1'b0) begin
      errors++;
      $display("FAIL oor_drain got v=%b e=%b want 0/0", out_Valid3, sel_Err3);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_Valid = 1'b0; in_Sel = '0; out_Ready = 1'b0;
    flush3 = 1'b0; in_Valid3 = 1'b0; in_Sel3 = '0; out_Ready3 = 1'b1;
    for (int k = 0; k < 4; k++) din[k] = '0;
    for (int k = 0; k < 3; k++) din3[k] = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_throughput();
    test_random();
    test_reset_midstream();
    test_out_of_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
